// File: rtl/wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_queue                                                           |
// | Register-file write-back queue merging Mem and Alu results in order.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     MemValid,
  input  logic [4:0]               MemAddr,
  input  logic [31:0]              MemData,
  output logic                     MemReady,
  input  logic                     AluValid,
  input  logic [4:0]               AluAddr,
  input  logic [31:0]              AluData,
  output logic                     AluReady,
  input  logic                     Flush,
  output logic                     RegWrite,
  output logic [4:0]               WriteAddr,
  output logic [31:0]              WriteData,
  output logic [31:0]              Busy,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W:0]   r_count;
  logic [4:0]         r_addr [DEPTH];
  logic [31:0]        r_data [DEPTH];

  logic               w_mem_hs;
  logic               w_alu_hs;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_push_addr;
  logic [31:0]        w_push_data;
  logic [c_PTR_W-1:0] w_off;

  assign Count = r_count;
  assign Full  = (r_count == (c_PTR_W+1)'(DEPTH));
  assign Empty = (r_count == '0);

  // Ready is held high during reset so a source is never stalled by it.
  assign MemReady = Reset | (!Full && !Flush);
  assign AluReady = Reset | (!Full && !Flush && !MemValid);

  assign w_mem_hs    = MemValid && MemReady;
  assign w_alu_hs    = AluValid && AluReady;
  assign w_push_addr = w_mem_hs ? MemAddr : AluAddr;
  assign w_push_data = w_mem_hs ? MemData : AluData;
  // Writes to r0 complete the handshake but are dropped here.
  assign w_push      = !Reset && (w_mem_hs || w_alu_hs) && (w_push_addr != 5'd0);

  assign RegWrite  = !Empty && !Flush;
  assign w_pop     = RegWrite;
  assign WriteAddr = Empty ? 5'd0  : r_addr[r_head];
  assign WriteData = Empty ? 32'd0 : r_data[r_head];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_addr[r_tail] <= w_push_addr;
      r_data[r_tail] <= w_push_data;
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    Busy  = '0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = c_PTR_W'(i) - r_head;
      if ({1'b0, w_off} < r_count) Busy[r_addr[i]] = 1'b1;
    end
    Busy[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_write_queue                                                        |
// | Scoreboard bench for wb_write_queue with directed vectors.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MemValid, AluValid, Flush;
  logic [4:0]  MemAddr, AluAddr;
  logic [31:0] MemData, AluData;
  logic        MemReady, AluReady, RegWrite, Full, Empty;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData, Busy;
  logic [$clog2(DEPTH):0] Count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] sb[$];
  logic mr, ar;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .Flush(Flush), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .Busy(Busy), .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the oldest expected entry.
  always @(negedge Clock) begin
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got write r%0d=0x%h, expected no write at %0t",
                 WriteAddr, WriteData, $time);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("write_addr", 32'(WriteAddr), 32'(e[36:32]));
        chk("write_data", WriteData, e[31:0]);
      end
    end
  end

  task automatic sync();
    @(posedge Clock);
    #1;
  endtask

  // One offer cycle: inputs set after an edge, Ready sampled mid-cycle.
  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       output logic o_mr, output logic o_ar);
    MemValid = mv; MemAddr = ma; MemData = md;
    AluValid = av; AluAddr = aa; AluData = ad;
    @(negedge Clock);
    o_mr = MemReady;
    o_ar = AluReady;
    @(posedge Clock);
    if (mv && o_mr && ma != 5'd0) sb.push_back({ma, md});
    if (av && o_ar && aa != 5'd0) sb.push_back({aa, ad});
    #1;
    MemValid = 1'b0;
    AluValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0;
    MemValid = 1'b0; MemAddr = '0; MemData = '0;
    AluValid = 1'b0; AluAddr = '0; AluData = '0;
    #2;
    chk("rst_empty",    32'(Empty), 32'd1);
    chk("rst_full",     32'(Full), 32'd0);
    chk("rst_count",    32'(Count), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_busy",     Busy, 32'd0);
    chk("rst_memready", 32'(MemReady), 32'd1);
    chk("rst_aluready", 32'(AluReady), 32'd1);
    // Offer during reset must not be recorded.
    MemValid = 1'b1; MemAddr = 5'd9; MemData = 32'h99;
    sync();
    MemValid = 1'b0;
    chk("rst_no_record", 32'(Count), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Single Alu write to r5.
    sync();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, mr, ar);
    chk("single_aluready", 32'(ar), 32'd1);
    @(negedge Clock);
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_busy",     Busy, 32'h20);
    chk("single_count",    32'(Count), 32'd1);
    @(negedge Clock);
    chk("single_empty_after", 32'(Empty), 32'd1);
    chk("single_busy_after",  Busy, 32'd0);

    // Mem has priority over Alu.
    sync();
    drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, mr, ar);
    chk("prio_memready", 32'(mr), 32'd1);
    chk("prio_aluready", 32'(ar), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd2, mr, ar);
    chk("prio_alu_retry", 32'(ar), 32'd1);
    repeat (3) @(negedge Clock);
    chk("prio_drained", 32'(sb.size()), 32'd0);

    // Write to r0 is accepted and dropped.
    sync();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, mr, ar);
    chk("r0_aluready", 32'(ar), 32'd1);
    @(negedge Clock);
    chk("r0_count",    32'(Count), 32'd0);
    chk("r0_regwrite", 32'(RegWrite), 32'd0);

    // Six back-to-back offers wrap the pointers.
    sync();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        drive(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 5'd0, 32'd0, mr, ar);
      else
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), mr, ar);
      chk("burst_ready", 32'(i % 2 == 0 ? mr : ar), 32'd1);
    end
    repeat (2) @(negedge Clock);
    chk("burst_drained", 32'(sb.size()), 32'd0);
    chk("burst_empty",   32'(Empty), 32'd1);
    chk("burst_notfull", 32'(Full), 32'd0);

    // Flush discards the pending r7 and rejects r9.
    sync();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h70, mr, ar);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h71, mr, ar);
    Flush = 1'b1;
    AluValid = 1'b1; AluAddr = 5'd9; AluData = 32'h90;
    sb.delete();
    @(negedge Clock);
    chk("flush_regwrite", 32'(RegWrite), 32'd0);
    chk("flush_aluready", 32'(AluReady), 32'd0);
    chk("flush_memready", 32'(MemReady), 32'd0);
    sync();
    Flush = 1'b0;
    AluValid = 1'b0;
    @(negedge Clock);
    chk("flush_count", 32'(Count), 32'd0);
    chk("flush_busy",  Busy, 32'd0);
    chk("flush_empty", 32'(Empty), 32'd1);

    // Asynchronous reset mid-drain, then resume.
    sync();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_000A, mr, ar);
    #2;
    Reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_regwrite",  32'(RegWrite), 32'd0);
    chk("arst_empty",     32'(Empty), 32'd1);
    chk("arst_count",     32'(Count), 32'd0);
    chk("arst_busy",      Busy, 32'd0);
    chk("arst_waddr",     32'(WriteAddr), 32'd0);
    chk("arst_wdata",     WriteData, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    sync();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h0000_000B, mr, ar);
    chk("resume_aluready", 32'(ar), 32'd1);
    @(negedge Clock);
    chk("resume_busy", Busy, 32'h800);
    @(negedge Clock);
    chk("resume_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
